// File: rtl/worm_pkg.sv
// worm_pkg: shared types for the worm trail monitor.
//   COORD_W  - coordinate width, matches the worm position stage outputs
//   coord_t  - packed {x,y} head coordinate
//   state_t  - monitor FSM states
package worm_pkg;

    localparam int unsigned COORD_W = 6;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        HIT   = 2'd2
    } state_t;

endpackage

// File: rtl/worm_trail_cam.sv
// worm_trail_cam: DEPTH-entry shift-register history of head positions with
// per-entry valid bits and a parallel equality match against din.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr         synchronous clear of all entries
//   push        shift din in as the newest entry (oldest drops when full)
//   din         coordinate to push and to compare against the history
//   match       combinational per-entry hit vector (valid entries only)
//   len         number of valid entries, 0..DEPTH
module worm_trail_cam
    import worm_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  coord_t                       din,
    output logic [DEPTH-1:0]             match,
    output logic [$clog2(DEPTH+1)-1:0]   len
);

    localparam int unsigned LEN_W = $clog2(DEPTH + 1);

    coord_t             r_entry [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [LEN_W-1:0]   r_len;

    // History shift register; entry 0 is the newest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_entry[i] <= '0;
            r_valid <= '0;
            r_len   <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) r_entry[i] <= '0;
            r_valid <= '0;
            r_len   <= '0;
        end else if (push) begin
            r_entry[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) r_entry[i] <= r_entry[i-1];
            r_valid <= {r_valid[DEPTH-2:0], 1'b1};
            if (r_len != LEN_W'(DEPTH)) r_len <= r_len + LEN_W'(1);
        end
    end

    // Match covers every valid entry, including the one about to be evicted
    always_comb begin
        match = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match[i] = r_valid[i] && (r_entry[i] == din);
        end
    end

    assign len = r_len;

endmodule

// File: rtl/worm_trail_monitor.sv
// worm_trail_monitor: samples worm head positions, keeps the recent trail,
// counts moves and flags self-collision (and optionally out-of-bounds).
// Optional feature: define WORM_BOUNDS_CHECK_EN to enable the GRID_MAX bound
// check; otherwise oob is tied to 0 and no bound compare is built.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   pos_valid           pos_x/pos_y carry a new head sample
//   pos_x, pos_y        head coordinate
//   clr                 synchronous clear, wins over pos_valid
//   collision, oob      sticky event flags
//   hit_x, hit_y        coordinate that caused the event, 0 otherwise
//   move_count          accepted moves, saturating
//   trail_len           valid history entries
//   busy                1 while tracking
module worm_trail_monitor
    import worm_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_W    = 8
`ifdef WORM_BOUNDS_CHECK_EN
   ,parameter int unsigned GRID_MAX = 39
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pos_valid,
    input  logic [COORD_W-1:0]           pos_x,
    input  logic [COORD_W-1:0]           pos_y,
    input  logic                         clr,
    output logic                         collision,
    output logic                         oob,
    output logic [COORD_W-1:0]           hit_x,
    output logic [COORD_W-1:0]           hit_y,
    output logic [CNT_W-1:0]             move_count,
    output logic [$clog2(DEPTH+1)-1:0]   trail_len,
    output logic                         busy
);

    state_t             r_state,      w_state_nxt;
    coord_t             r_head,       w_head_nxt;
    coord_t             r_hit,        w_hit_nxt;
    logic               r_collision,  w_collision_nxt;
    logic               r_oob,        w_oob_nxt;
    logic [CNT_W-1:0]   r_move_count, w_move_count_nxt;
    logic               r_busy,       w_busy_nxt;

    coord_t             w_sample;
    logic               w_push;
    logic               w_out_of_bounds;
    logic [DEPTH-1:0]   w_match;

    assign w_sample = {pos_x, pos_y};

`ifdef WORM_BOUNDS_CHECK_EN
    assign w_out_of_bounds = (pos_x > COORD_W'(GRID_MAX)) || (pos_y > COORD_W'(GRID_MAX));
`else
    assign w_out_of_bounds = 1'b0;
`endif

    worm_trail_cam #(
        .DEPTH (DEPTH)
    ) u_cam (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (w_push),
        .din   (w_sample),
        .match (w_match),
        .len   (trail_len)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_head       <= '0;
            r_hit        <= '0;
            r_collision  <= 1'b0;
            r_oob        <= 1'b0;
            r_move_count <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_head       <= w_head_nxt;
            r_hit        <= w_hit_nxt;
            r_collision  <= w_collision_nxt;
            r_oob        <= w_oob_nxt;
            r_move_count <= w_move_count_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_head_nxt       = r_head;
        w_hit_nxt        = r_hit;
        w_collision_nxt  = r_collision;
        w_oob_nxt        = r_oob;
        w_move_count_nxt = r_move_count;
        w_push           = 1'b0;

        if (clr) begin
            w_state_nxt      = EMPTY;
            w_head_nxt       = '0;
            w_hit_nxt        = '0;
            w_collision_nxt  = 1'b0;
            w_oob_nxt        = 1'b0;
            w_move_count_nxt = '0;
        end else if (pos_valid) begin
            unique case (r_state)
                EMPTY: begin
                    if (w_out_of_bounds) begin
                        w_oob_nxt   = 1'b1;
                        w_hit_nxt   = w_sample;
                        w_state_nxt = HIT;
                    end else begin
                        w_push      = 1'b1;
                        w_head_nxt  = w_sample;
                        w_state_nxt = TRACK;
                    end
                end
                TRACK: begin
                    // A stationary head is neither a move nor a collision
                    if (w_sample != r_head) begin
                        if (w_out_of_bounds) begin
                            w_oob_nxt   = 1'b1;
                            w_hit_nxt   = w_sample;
                            w_state_nxt = HIT;
                        end else if (|w_match) begin
                            w_collision_nxt = 1'b1;
                            w_hit_nxt       = w_sample;
                            w_state_nxt     = HIT;
                        end else begin
                            w_push     = 1'b1;
                            w_head_nxt = w_sample;
                            if (r_move_count != {CNT_W{1'b1}}) begin
                                w_move_count_nxt = r_move_count + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == TRACK);
    end

    assign collision  = r_collision;
    assign oob        = r_oob;
    assign hit_x      = r_hit.x;
    assign hit_y      = r_hit.y;
    assign move_count = r_move_count;
    assign busy       = r_busy;

endmodule
